// File: rtl/ddr_pkg.sv
// Shared DDR write-path definitions: FSM state encoding, toggle counts and
// the default write-latency field width.
package ddr_pkg;

    localparam int unsigned WLW_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_PRE    = 3'd2,
        ST_TOGGLE = 3'd3,
        ST_POST   = 3'd4
    } state_e;

    // Toggle counter reload values; the counter runs down to 0 inclusive.
    localparam logic [1:0] TOG_BL4 = 2'd1;
    localparam logic [1:0] TOG_BL8 = 2'd3;

endpackage

// File: rtl/dqs_write_sequencer.sv
// DQS drive sequencer for one DDR2 byte lane: a 1-entry request slot feeding a
// write-latency / preamble / toggle / postamble FSM with registered IOB controls.
module dqs_write_sequencer
    import ddr_pkg::*;
#(
    parameter int unsigned WLW    = WLW_DEFAULT,
    parameter int unsigned QDEPTH = 1
) (
    input  logic           MCLK,
    input  logic           ResetL,
    input  logic           wrStart,
    input  logic [WLW-1:0] wrLat,
    input  logic           burst8,
    output logic           wrReady,
    output logic           busy,
    output logic           ODDRD1,
    output logic           ODDRD2,
    output logic           preDQSenL,
    output logic           wdataEn
);

    if (QDEPTH != 1) begin : g_qdepth_check
        $fatal(1, "dqs_write_sequencer: QDEPTH must be 1");
    end

    state_e         state_q, state_d;
    logic [WLW-1:0] lat_q, lat_d;
    logic [1:0]     tog_q, tog_d;

    logic           pend_vld_q, pend_vld_d;
    logic [WLW-1:0] pend_lat_q, pend_lat_d;
    logic           pend_b8_q, pend_b8_d;

    logic           oddrd1_q, oddrd1_d;
    logic           oddrd2_q, oddrd2_d;
    logic           dqs_en_l_q, dqs_en_l_d;
    logic           wdata_en_q, wdata_en_d;

    logic           pop;
    logic           accept;

    // The slot counts as free while IDLE is popping it, so a request can be
    // accepted in the same cycle the previous one moves into the FSM.
    assign pop     = (state_q == ST_IDLE) && pend_vld_q;
    assign wrReady = !pend_vld_q || pop;
    assign accept  = wrStart && wrReady;
    assign busy    = (state_q != ST_IDLE) || pend_vld_q;

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        tog_d      = tog_q;
        pend_vld_d = pend_vld_q;
        pend_lat_d = pend_lat_q;
        pend_b8_d  = pend_b8_q;

        if (pop) begin
            pend_vld_d = 1'b0;
        end
        if (accept) begin
            pend_vld_d = 1'b1;
            pend_lat_d = wrLat;
            pend_b8_d  = burst8;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (pend_vld_q) begin
                    lat_d   = pend_lat_q;
                    tog_d   = pend_b8_q ? TOG_BL8 : TOG_BL4;
                    state_d = (pend_lat_q != '0) ? ST_WAIT : ST_PRE;
                end
            end
            ST_WAIT: begin
                lat_d = lat_q - WLW'(1);
                if (lat_q == WLW'(1)) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                state_d = ST_TOGGLE;
            end
            ST_TOGGLE: begin
                if (tog_q == 2'd0) begin
                    state_d = ST_POST;
                end else begin
                    tog_d = tog_q - 2'd1;
                end
            end
            ST_POST: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flops are loaded from the next state so they describe the state
    // occupied in the same cycle.
    always_comb begin
        oddrd1_d   = (state_d == ST_TOGGLE);
        oddrd2_d   = 1'b0;
        wdata_en_d = (state_d == ST_TOGGLE);
        dqs_en_l_d = !((state_d == ST_PRE) || (state_d == ST_TOGGLE) ||
                       (state_d == ST_POST));
    end

    always_ff @(posedge MCLK or negedge ResetL) begin
        if (!ResetL) begin
            state_q    <= ST_IDLE;
            lat_q      <= '0;
            tog_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_lat_q <= '0;
            pend_b8_q  <= 1'b0;
            oddrd1_q   <= 1'b0;
            oddrd2_q   <= 1'b0;
            dqs_en_l_q <= 1'b1;
            wdata_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_q      <= lat_d;
            tog_q      <= tog_d;
            pend_vld_q <= pend_vld_d;
            pend_lat_q <= pend_lat_d;
            pend_b8_q  <= pend_b8_d;
            oddrd1_q   <= oddrd1_d;
            oddrd2_q   <= oddrd2_d;
            dqs_en_l_q <= dqs_en_l_d;
            wdata_en_q <= wdata_en_d;
        end
    end

    assign ODDRD1    = oddrd1_q;
    assign ODDRD2    = oddrd2_q;
    assign preDQSenL = dqs_en_l_q;
    assign wdataEn   = wdata_en_q;

endmodule

// File: tb/tb_dqs_write_sequencer.sv
// Directed, table-driven bench for dqs_write_sequencer with hand-computed
// per-cycle expectations plus an asynchronous-reset sequence.
module tb_dqs_write_sequencer;

    localparam int unsigned W = 4;

    // Expected output bundles: {wrReady, busy, ODDRD1, ODDRD2, preDQSenL, wdataEn}
    localparam logic [5:0] E_IDLE   = 6'b100010;
    localparam logic [5:0] E_BUSY_R = 6'b110010;
    localparam logic [5:0] E_BUSY_F = 6'b010010;
    localparam logic [5:0] E_DRV_R  = 6'b110000;
    localparam logic [5:0] E_DRV_F  = 6'b010000;
    localparam logic [5:0] E_TOG_R  = 6'b111001;
    localparam logic [5:0] E_TOG_F  = 6'b011001;

    logic         MCLK    = 1'b0;
    logic         ResetL  = 1'b0;
    logic         wrStart = 1'b0;
    logic [W-1:0] wrLat   = '0;
    logic         burst8  = 1'b0;
    logic         wrReady;
    logic         busy;
    logic         ODDRD1;
    logic         ODDRD2;
    logic         preDQSenL;
    logic         wdataEn;

    int errors = 0;
    int checks = 0;

    always #5 MCLK = ~MCLK;

    dqs_write_sequencer #(.WLW(W), .QDEPTH(1)) dut (
        .MCLK      (MCLK),
        .ResetL    (ResetL),
        .wrStart   (wrStart),
        .wrLat     (wrLat),
        .burst8    (burst8),
        .wrReady   (wrReady),
        .busy      (busy),
        .ODDRD1    (ODDRD1),
        .ODDRD2    (ODDRD2),
        .preDQSenL (preDQSenL),
        .wdataEn   (wdataEn)
    );

    typedef struct {
        logic         st;
        logic [W-1:0] lat;
        logic         b8;
        logic [5:0]   exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic [W-1:0] lat, logic b8, logic [5:0] exp);
        vec_t v;
        v.st  = st;
        v.lat = lat;
        v.b8  = b8;
        v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {wrReady, busy, ODDRD1, ODDRD2, preDQSenL, wdataEn};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: rdy/busy/d1/d2/enL/wden got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge MCLK);
        #1;
    endtask

    logic [5:0] rst_seq[7];

    initial begin
        // A: BL4, wrLat=3
        vecs.push_back(mk(1'b1, 4'd3, 1'b0, E_IDLE));
        vecs.push_back(mk(1'b0, 4'd3, 1'b0, E_BUSY_R));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 4'd3, 1'b0, E_BUSY_R));
        vecs.push_back(mk(1'b0, 4'd3, 1'b0, E_DRV_R));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, 4'd3, 1'b0, E_TOG_R));
        vecs.push_back(mk(1'b0, 4'd3, 1'b0, E_DRV_R));
        vecs.push_back(mk(1'b0, 4'd3, 1'b0, E_IDLE));
        // B: BL8, wrLat=0
        vecs.push_back(mk(1'b1, 4'd0, 1'b1, E_IDLE));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, E_BUSY_R));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, E_DRV_R));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1'b0, 4'd0, 1'b1, E_TOG_R));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, E_DRV_R));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, E_IDLE));
        // C: two accepted pulses (BL4, wrLat=1), third dropped while slot full
        vecs.push_back(mk(1'b1, 4'd1, 1'b0, E_IDLE));
        vecs.push_back(mk(1'b1, 4'd1, 1'b0, E_BUSY_R));
        vecs.push_back(mk(1'b1, 4'd0, 1'b1, E_BUSY_F));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_DRV_F));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_TOG_F));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_DRV_F));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_BUSY_R));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_BUSY_R));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_DRV_R));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_TOG_R));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_DRV_R));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_IDLE));
        vecs.push_back(mk(1'b0, 4'd0, 1'b0, E_IDLE));
        // D: wrLat=2 accepted, then inputs change to wrLat=7 / BL8
        vecs.push_back(mk(1'b1, 4'd2, 1'b0, E_IDLE));
        vecs.push_back(mk(1'b0, 4'd7, 1'b1, E_BUSY_R));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, 4'd7, 1'b1, E_BUSY_R));
        vecs.push_back(mk(1'b0, 4'd7, 1'b1, E_DRV_R));
        for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, 4'd7, 1'b1, E_TOG_R));
        vecs.push_back(mk(1'b0, 4'd7, 1'b1, E_DRV_R));
        vecs.push_back(mk(1'b0, 4'd7, 1'b1, E_IDLE));

        // Post-reset BL4 wrLat=0 burst: accept, pop, PRE, TOG, TOG, POST, IDLE
        rst_seq[0] = E_IDLE;
        rst_seq[1] = E_BUSY_R;
        rst_seq[2] = E_DRV_R;
        rst_seq[3] = E_TOG_R;
        rst_seq[4] = E_TOG_R;
        rst_seq[5] = E_DRV_R;
        rst_seq[6] = E_IDLE;

        #12;
        check("reset_state", E_IDLE);
        ResetL = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            wrStart = vecs[i].st;
            wrLat   = vecs[i].lat;
            burst8  = vecs[i].b8;
            check($sformatf("vec%0d", i), vecs[i].exp);
            tick();
        end
        wrStart = 1'b0;

        // Asynchronous reset in the middle of a BL8 toggle phase
        wrStart = 1'b1;
        wrLat   = 4'd0;
        burst8  = 1'b1;
        tick();
        wrStart = 1'b0;
        tick();
        tick();
        tick();
        check("rst_pre_toggle", E_TOG_R);
        #2;
        ResetL = 1'b0;
        #1;
        check("rst_async_mid_toggle", E_IDLE);
        ResetL = 1'b1;
        tick();

        burst8 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wrStart = (i == 0);
            check($sformatf("post_rst%0d", i), rst_seq[i]);
            tick();
        end
        wrStart = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
